// File: rtl/fetch_queue.sv
// Instruction fetch buffer: circular FIFO of {pc, instr} beats between the I-cache
// controller and decode. Optional same-cycle bypass when FETCHQ_BYPASS_EN is defined.
module fetch_queue #(
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [63:0]              in_pc_instr,
    input  logic                     flush,
    input  logic                     dec_ready,
    output logic                     out_valid,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic                     stop_fetch,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [63:0]   mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          stop_reg;
    logic          overflow_reg;

    logic          empty;
    logic          full;
    logic          bypass;
    logic          pop;
    logic          pop_mem;
    logic          push;
    logic          drop;
    logic [63:0]   head;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));
    assign head  = mem[rd_ptr_reg];

`ifdef FETCHQ_BYPASS_EN
    // An arriving beat into an empty queue is shown to decode in the same cycle.
    assign bypass = empty & in_valid & ~flush;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = ~empty | bypass;
    assign pop       = out_valid & dec_ready;
    // Only a pop of a stored entry moves the read side; a bypassed beat never touched memory.
    assign pop_mem   = pop & ~empty;
    assign push      = in_valid & ~flush & (~full | pop) & ~(bypass & dec_ready);
    assign drop      = in_valid & ~flush & full & ~pop;

    always_comb begin
        out_pc    = 32'h0;
        out_instr = 32'h0;
        if (bypass) begin
            out_pc    = in_pc_instr[63:32];
            out_instr = in_pc_instr[31:0];
        end else if (~empty) begin
            out_pc    = head[63:32];
            out_instr = head[31:0];
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push)    wr_ptr_next = wr_ptr_reg + AW'(1);
            if (pop_mem) rd_ptr_next = rd_ptr_reg + AW'(1);
            count_next = count_reg + CW'(push) - CW'(pop_mem);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            stop_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            // count_next is already zero on flush, so this also clears stop on flush.
            stop_reg   <= (count_next >= CW'(AFULL_LEVEL));
            if (drop) overflow_reg <= 1'b1;
        end
    end

    // Storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= in_pc_instr;
    end

    assign stop_fetch = stop_reg;
    assign overflow   = overflow_reg;
    assign count      = count_reg;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4, AFULL_LEVEL=3): vector table plus
// hand-written sequences for the combinational-path and asynchronous-reset cases.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_pc_instr;
    logic        flush;
    logic        dec_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        stop_fetch;
    logic        overflow;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_queue #(.DEPTH(4), .AFULL_LEVEL(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_pc_instr (in_pc_instr),
        .flush       (flush),
        .dec_ready   (dec_ready),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .stop_fetch  (stop_fetch),
        .overflow    (overflow),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fl;
        logic        dr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [2:0]  e_count;
        logic        e_stop;
        logic        e_ovf;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid    = 1'b0;
        in_pc_instr = 64'h0;
        flush       = 1'b0;
        dec_ready   = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic ev, input logic [31:0] epc,
                               input logic [31:0] ein, input logic [2:0] ecnt,
                               input logic estop, input logic eovf);
        check({tag, "_valid"}, 32'(out_valid), 32'(ev));
        check({tag, "_pc"},    out_pc, epc);
        check({tag, "_instr"}, out_instr, ein);
        check({tag, "_count"}, 32'(count), 32'(ecnt));
        check({tag, "_stop"},  32'(stop_fetch), 32'(estop));
        check({tag, "_ovf"},   32'(overflow), 32'(eovf));
    endtask

    initial begin
        //         iv  pc           instr         fl  dr  ev  e_pc         e_instr       cnt stop ovf
        vecs[0]  = '{1, 32'h10, 32'h00500093, 0, 0, 1, 32'h10, 32'h00500093, 1, 0, 0};
        vecs[1]  = '{1, 32'h14, 32'h00100113, 0, 0, 1, 32'h10, 32'h00500093, 2, 0, 0};
        vecs[2]  = '{1, 32'h18, 32'h00200193, 0, 0, 1, 32'h10, 32'h00500093, 3, 1, 0};
        vecs[3]  = '{0, 32'h0,  32'h0,        0, 1, 1, 32'h14, 32'h00100113, 2, 0, 0};
        vecs[4]  = '{1, 32'h1C, 32'h00300213, 0, 0, 1, 32'h14, 32'h00100113, 3, 1, 0};
        vecs[5]  = '{1, 32'h20, 32'h00400293, 0, 0, 1, 32'h14, 32'h00100113, 4, 1, 0};
        vecs[6]  = '{1, 32'h50, 32'h11111111, 0, 0, 1, 32'h14, 32'h00100113, 4, 1, 1};
        vecs[7]  = '{1, 32'h54, 32'h22222222, 0, 1, 1, 32'h18, 32'h00200193, 4, 1, 1};
        vecs[8]  = '{0, 32'h0,  32'h0,        0, 1, 1, 32'h1C, 32'h00300213, 3, 1, 1};
        vecs[9]  = '{0, 32'h0,  32'h0,        0, 1, 1, 32'h20, 32'h00400293, 2, 0, 1};
        vecs[10] = '{0, 32'h0,  32'h0,        0, 1, 1, 32'h54, 32'h22222222, 1, 0, 1};
        vecs[11] = '{1, 32'h60, 32'h33333333, 0, 0, 1, 32'h54, 32'h22222222, 2, 0, 1};
        vecs[12] = '{1, 32'h64, 32'h44444444, 0, 0, 1, 32'h54, 32'h22222222, 3, 1, 1};
        vecs[13] = '{1, 32'hC8, 32'hDEADBEEF, 1, 1, 0, 32'h0,  32'h0,        0, 0, 1};
        vecs[14] = '{0, 32'h0,  32'h0,        0, 1, 0, 32'h0,  32'h0,        0, 0, 1};
        vecs[15] = '{1, 32'h70, 32'h55555555, 0, 0, 1, 32'h70, 32'h55555555, 1, 0, 1};
        vecs[16] = '{1, 32'h74, 32'h66666666, 0, 1, 1, 32'h74, 32'h66666666, 1, 0, 1};
        vecs[17] = '{0, 32'h0,  32'h0,        0, 1, 0, 32'h0,  32'h0,        0, 0, 1};

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Table: inputs held across one rising edge, then removed before sampling.
        for (int i = 0; i < NV; i++) begin
            in_valid    = vecs[i].iv;
            in_pc_instr = {vecs[i].pc, vecs[i].instr};
            flush       = vecs[i].fl;
            dec_ready   = vecs[i].dr;
            @(posedge clk);
            #1;
            idle_inputs();
            #1;
            check_state($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_pc,
                        vecs[i].e_instr, vecs[i].e_count, vecs[i].e_stop, vecs[i].e_ovf);
            $display("vector %0d: valid=%0b pc=%h instr=%h count=%0d stop=%0b ovf=%0b",
                     i, out_valid, out_pc, out_instr, count, stop_fetch, overflow);
        end

        // Empty queue, beat arriving with decode ready: combinational view before the edge.
        in_valid    = 1'b1;
        in_pc_instr = {32'h20, 32'h77777777};
        dec_ready   = 1'b1;
        #1;
`ifdef FETCHQ_BYPASS_EN
        check("byp_valid", 32'(out_valid), 32'h1);
        check("byp_pc",    out_pc, 32'h20);
        check("byp_instr", out_instr, 32'h77777777);
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check("byp_count", 32'(count), 32'h0);
        check("byp_after_valid", 32'(out_valid), 32'h0);
`else
        check("nocomb_valid", 32'(out_valid), 32'h0);
        check("nocomb_pc",    out_pc, 32'h0);
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check("nocomb_count", 32'(count), 32'h1);
        check("nocomb_pc_next", out_pc, 32'h20);
        dec_ready = 1'b1;
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check("nocomb_drain", 32'(count), 32'h0);
`endif
        $display("comb-path sequence: valid=%0b count=%0d", out_valid, count);

        // Build count=2, then assert reset mid-cycle; it must act without a clock edge.
        for (int k = 0; k < 2; k++) begin
            in_valid    = 1'b1;
            in_pc_instr = {32'h80 + 32'(4 * k), 32'hA0A0A0A0};
            @(posedge clk);
            #1;
            idle_inputs();
        end
        #1;
        check("prerst_count", 32'(count), 32'h2);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_state("asyncrst", 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
        $display("async reset: valid=%0b count=%0d stop=%0b ovf=%0b",
                 out_valid, count, stop_fetch, overflow);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("postrst_count", 32'(count), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
